// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// R-type functs, ALU control codes and datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StRExec  = 4'd7,
    StRWb    = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StAddiEx = 4'd11,
    StAddiWb = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;
  localparam logic [2:0] AluBeq = 3'b111;

  localparam logic [1:0] AluSrcBReg    = 2'b00;
  localparam logic [1:0] AluSrcBFour   = 2'b01;
  localparam logic [1:0] AluSrcBImm    = 2'b10;
  localparam logic [1:0] AluSrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  function automatic logic op_is_mem(input logic [5:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, control strobes out.
interface mips_multicycle_ctrl_if;

  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;

  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUControl;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSource, ALUControl, Illegal, State
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSource, ALUControl, Illegal, State
  );

endinterface

// File: rtl/alu_func_decoder.sv
// Combinational R-type funct decode into an ALU control code plus a legality flag.
module alu_func_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl,
  output logic       FunctLegal
);

  always_comb begin
    ALUControl = AluAdd;
    FunctLegal = 1'b1;
    unique case (Funct)
      FunctAdd: ALUControl = AluAdd;
      FunctSub: ALUControl = AluSub;
      FunctAnd: ALUControl = AluAnd;
      FunctOr:  ALUControl = AluOr;
      FunctSlt: ALUControl = AluSlt;
      default:  FunctLegal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: Moore decode of the registered state, with
// PCEn/IRWrite qualified by MemReady/Zero and REXEC ALU code taken from Funct.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input logic                  Clk,
  input logic                  Rst_n,
  mips_multicycle_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic       is_load_q, is_load_d;
  logic [2:0] dec_alu;
  logic       dec_legal;

  alu_func_decoder u_alu_func_decoder (
    .Funct      (bus.Funct),
    .ALUControl (dec_alu),
    .FunctLegal (dec_legal)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    is_load_d      = is_load_q;
    bus.PCEn       = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = AluSrcBReg;
    bus.PCSource   = PcSrcAlu;
    bus.ALUControl = AluAdd;
    bus.Illegal    = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = AluSrcBFour;
        bus.IRWrite = bus.MemReady;
        bus.PCEn    = bus.MemReady;
        if (bus.MemReady) state_d = StDecode;
      end

      // Branch target precomputed into ALUOut while the opcode is decoded.
      StDecode: begin
        bus.ALUSrcB = AluSrcBImmSh2;
        if (op_is_mem(bus.Opcode)) begin
          is_load_d = (bus.Opcode == OpLw);
          state_d   = StMemAdr;
        end else begin
          unique case (bus.Opcode)
            OpRtype: begin
              if (dec_legal) begin
                state_d = StRExec;
              end else begin
                bus.Illegal = 1'b1;
                state_d     = StFetch;
              end
            end
            OpBeq:   state_d = StBranch;
            OpJ:     state_d = StJump;
            OpAddi:  state_d = StAddiEx;
            default: begin
              bus.Illegal = 1'b1;
              state_d     = StFetch;
            end
          endcase
        end
      end

      StMemAdr: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = AluSrcBImm;
        state_d     = is_load_q ? StMemRd : StMemWr;
      end

      StMemRd: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.MemReady) state_d = StMemWb;
      end

      StMemWb: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        state_d      = StFetch;
      end

      StMemWr: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.MemReady) state_d = StFetch;
      end

      StRExec: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = AluSrcBReg;
        bus.ALUControl = dec_alu;
        state_d        = StRWb;
      end

      StRWb: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        state_d      = StFetch;
      end

      StAddiEx: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = AluSrcBImm;
        state_d     = StAddiWb;
      end

      StAddiWb: begin
        bus.RegWrite = 1'b1;
        state_d      = StFetch;
      end

      StBranch: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = AluSrcBReg;
        bus.ALUControl = AluBeq;
        bus.PCSource   = PcSrcAluOut;
        bus.PCEn       = bus.Zero;
        state_d        = StFetch;
      end

      StJump: begin
        bus.PCSource = PcSrcJump;
        bus.PCEn     = 1'b1;
        state_d      = StFetch;
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.State = state_q;

endmodule
